// File: rtl/uart_load_ram.sv
// CPU data RAM with a UART bulk-load engine: frames of N, N*BYTES data bytes
// (low byte first) and a CRC-8 (poly 0x07) are written from address 0 upward.
module uart_load_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] addrM,
  input  logic [DATA_W-1:0] write_dataM,
  output logic [DATA_W-1:0] read_dataM,
  input  logic              load_start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              load_busy,
  output logic              cpu_stall,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   load_count,
  output logic [2:0]        dbg_state
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(BYTES - 1);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [8:0]       DEPTH_B   = 9'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_CRC  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [7:0]        r_crc;
  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_count;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_asm;
  logic              r_err;

  logic              w_busy;
  logic              w_len_bad;
  logic              w_last_lane;
  logic              w_last_word;
  logic              w_load_we;
  logic              w_cpu_we;
  logic              w_addr_ok;
  logic [7:0]        w_crc_nxt;
  logic [DATA_W-1:0] w_word;

  function automatic logic [7:0] crc8_fold(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int k = 0; k < 8; k++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  // rx_valid is a one-cycle strobe with no back-pressure: a byte is taken on
  // the falling edge where rx_valid=1 and the engine is in LEN, DATA or CRC.
  assign w_busy      = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CRC);
  assign w_len_bad   = (rx_byte == 8'd0) || ({1'b0, rx_byte} > DEPTH_B);
  assign w_last_lane = (r_idx == LAST_LANE);
  assign w_last_word = (CNT_W'(r_count + 1'b1) == r_len);
  assign w_crc_nxt   = crc8_fold(r_crc, rx_byte);
  assign w_load_we   = (r_state == S_DATA) && rx_valid && w_last_lane;
  assign w_cpu_we    = write_en && !w_busy && w_addr_ok;
  assign w_addr_ok   = ({1'b0, addrM} < DEPTH_C);

  always_comb begin
    w_word = r_asm;
    w_word[r_idx*8 +: 8] = rx_byte;
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (load_start) w_state_nxt = S_LEN;
      S_LEN:  if (rx_valid)   w_state_nxt = w_len_bad ? S_DONE : S_DATA;
      S_DATA: if (rx_valid && w_last_lane && w_last_word) w_state_nxt = S_CRC;
      S_CRC:  if (rx_valid)   w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      r_crc   <= 8'd0;
      r_len   <= '0;
      r_count <= '0;
      r_idx   <= '0;
      r_asm   <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= DATA_W'(i);
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load_start) begin
            r_crc   <= 8'd0;
            r_len   <= '0;
            r_count <= '0;
            r_idx   <= '0;
            r_asm   <= '0;
            r_err   <= 1'b0;
          end
        end
        S_LEN: begin
          if (rx_valid) begin
            if (w_len_bad) begin
              r_err <= 1'b1;
            end else begin
              r_len <= CNT_W'(rx_byte);
              r_crc <= w_crc_nxt;
            end
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            r_crc <= w_crc_nxt;
            r_asm <= w_word;
            if (w_last_lane) begin
              r_idx   <= '0;
              r_count <= r_count + 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_CRC: begin
          if (rx_valid && (rx_byte != r_crc)) r_err <= 1'b1;
        end
        default: ;
      endcase

      // CPU writes are only possible when the loader is idle, so the ports never collide.
      if (w_load_we) begin
        r_mem[r_count[ADDR_W-1:0]] <= w_word;
      end else if (w_cpu_we) begin
        r_mem[addrM] <= write_dataM;
      end
    end
  end

  assign read_dataM = w_addr_ok ? r_mem[addrM] : '0;
  assign load_busy  = w_busy;
  assign cpu_stall  = w_busy;
  assign load_done  = (r_state == S_DONE);
  assign load_err   = r_err;
  assign load_count = r_count;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_uart_load_ram.sv
// Directed bench for uart_load_ram: reset contents, good/bad frames, length
// errors, CPU stall, ignored inputs and reset in the middle of a frame.
module tb_uart_load_ram;

  logic        clk;
  logic        reset;
  logic        write_en;
  logic [3:0]  addrM;
  logic [15:0] write_dataM;
  logic [15:0] read_dataM;
  logic        load_start;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        load_busy;
  logic        cpu_stall;
  logic        load_done;
  logic        load_err;
  logic [4:0]  load_count;
  logic [2:0]  dbg_state;

  int errors;
  int checks;
  int done_cnt;

  uart_load_ram #(.DATA_W(16), .DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .write_en(write_en), .addrM(addrM),
    .write_dataM(write_dataM), .read_dataM(read_dataM), .load_start(load_start),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .load_busy(load_busy),
    .cpu_stall(cpu_stall), .load_done(load_done), .load_err(load_err),
    .load_count(load_count), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (load_done === 1'b1) done_cnt++;

  function automatic logic [7:0] ref_crc(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    for (int k = 0; k < 8; k++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  // driver tasks: inputs change just after rising edges, DUT acts on falling edges
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    @(posedge clk); load_start = 1'b1;
    @(posedge clk); load_start = 1'b0; #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); rx_valid = 1'b1; rx_byte = b;
    @(posedge clk); rx_valid = 1'b0; #1;
  endtask

  task automatic cpu_write(input logic [3:0] a, input logic [15:0] d);
    @(posedge clk); write_en = 1'b1; addrM = a; write_dataM = d;
    @(posedge clk); write_en = 1'b0; #1;
  endtask

  task automatic test_reset();
    for (int a = 0; a < 16; a++) begin
      addrM = 4'(a); #1;
      checks++;
      if (read_dataM !== 16'(a)) begin
        $display("FAIL reset_mem[%0d]: got %h expected %h", a, read_dataM, 16'(a)); errors++;
      end
    end
    checks++;
    if ({load_busy, cpu_stall, load_done, load_err, load_count, dbg_state} !== 12'd0) begin
      $display("FAIL reset_outputs: busy=%b stall=%b done=%b err=%b count=%0d state=%0d expected all 0",
               load_busy, cpu_stall, load_done, load_err, load_count, dbg_state); errors++;
    end
  endtask

  task automatic test_good_frame();
    int d0;
    cpu_write(4'd0, 16'h7777);
    addrM = 4'd0;
    pulse_start();
    checks++;
    if (load_busy !== 1'b1 || cpu_stall !== 1'b1) begin
      $display("FAIL good_busy_rise: busy=%b stall=%b expected 1 1", load_busy, cpu_stall); errors++;
    end
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    checks++;
    if (read_dataM !== 16'h0000 || load_count !== 5'd1) begin
      $display("FAIL good_word_write: mem0=%h count=%0d expected 0000 1", read_dataM, load_count); errors++;
    end
    d0 = done_cnt;
    send_byte(8'h6B);
    checks++;
    if (load_done !== 1'b1 || load_busy !== 1'b0 || load_err !== 1'b0) begin
      $display("FAIL good_done: done=%b busy=%b err=%b expected 1 0 0", load_done, load_busy, load_err); errors++;
    end
    tick(); tick();
    checks++;
    if (load_done !== 1'b0 || (done_cnt - d0) !== 1) begin
      $display("FAIL good_done_pulse: done=%b pulses=%0d expected 0 1", load_done, done_cnt - d0); errors++;
    end
    addrM = 4'd1; #1;
    checks++;
    if (read_dataM !== 16'h0001 || load_count !== 5'd1) begin
      $display("FAIL good_mem1: mem1=%h count=%0d expected 0001 1", read_dataM, load_count); errors++;
    end
  endtask

  task automatic test_bad_crc();
    cpu_write(4'd0, 16'h7777);
    addrM = 4'd0;
    pulse_start();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h6A);
    checks++;
    if (load_done !== 1'b1 || load_err !== 1'b1 || load_count !== 5'd1) begin
      $display("FAIL badcrc_done: done=%b err=%b count=%0d expected 1 1 1", load_done, load_err, load_count); errors++;
    end
    tick(); tick();
    checks++;
    if (load_err !== 1'b1 || read_dataM !== 16'h0000) begin
      $display("FAIL badcrc_held: err=%b mem0=%h expected 1 0000", load_err, read_dataM); errors++;
    end
  endtask

  task automatic test_len_errors();
    pulse_start();
    checks++;
    if (load_err !== 1'b0) begin
      $display("FAIL len_err_clear: err=%b expected 0", load_err); errors++;
    end
    send_byte(8'h00);
    checks++;
    if (load_err !== 1'b1 || load_done !== 1'b1 || load_busy !== 1'b0 || load_count !== 5'd0) begin
      $display("FAIL len_zero: err=%b done=%b busy=%b count=%0d expected 1 1 0 0",
               load_err, load_done, load_busy, load_count); errors++;
    end
    tick();
    checks++;
    if (load_done !== 1'b0 || load_err !== 1'b1) begin
      $display("FAIL len_zero_after: done=%b err=%b expected 0 1", load_done, load_err); errors++;
    end
    pulse_start();
    send_byte(8'h11);
    checks++;
    if (load_err !== 1'b1 || load_done !== 1'b1 || load_count !== 5'd0) begin
      $display("FAIL len_17: err=%b done=%b count=%0d expected 1 1 0", load_err, load_done, load_count); errors++;
    end
    tick();
    addrM = 4'd2; #1;
    checks++;
    if (read_dataM !== 16'h0002 || dbg_state !== 3'd0) begin
      $display("FAIL len_no_write: mem2=%h state=%0d expected 0002 0", read_dataM, dbg_state); errors++;
    end
  endtask

  task automatic test_stall();
    pulse_start();
    cpu_write(4'd5, 16'hBEEF);
    checks++;
    if (read_dataM !== 16'h0005) begin
      $display("FAIL stall_drop: mem5=%h expected 0005", read_dataM); errors++;
    end
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h6B);
    tick();
    cpu_write(4'd5, 16'hBEEF);
    checks++;
    if (read_dataM !== 16'hBEEF || load_err !== 1'b0) begin
      $display("FAIL stall_after: mem5=%h err=%b expected beef 0", read_dataM, load_err); errors++;
    end
  endtask

  task automatic test_ignored_inputs();
    send_byte(8'h05);
    checks++;
    if (dbg_state !== 3'd0 || load_count !== 5'd1 || load_busy !== 1'b0) begin
      $display("FAIL idle_rx_ignored: state=%0d count=%0d busy=%b expected 0 1 0", dbg_state, load_count, load_busy); errors++;
    end
    @(posedge clk); load_start = 1'b1; rx_valid = 1'b1; rx_byte = 8'h00;
    @(posedge clk); load_start = 1'b0; rx_valid = 1'b0; #1;
    checks++;
    if (dbg_state !== 3'd1 || load_err !== 1'b0) begin
      $display("FAIL start_with_byte: state=%0d err=%b expected 1 0", dbg_state, load_err); errors++;
    end
    send_byte(8'h00);
    load_start = 1'b1;
    @(posedge clk); load_start = 1'b0; #1;
    checks++;
    if (dbg_state !== 3'd0 || load_err !== 1'b1) begin
      $display("FAIL done_start_ignored: state=%0d err=%b expected 0 1", dbg_state, load_err); errors++;
    end
  endtask

  task automatic test_reset_mid_frame();
    int d0;
    cpu_write(4'd3, 16'h1234);
    pulse_start();
    send_byte(8'h02); send_byte(8'hAA);
    checks++;
    if (dbg_state !== 3'd2) begin
      $display("FAIL midreset_in_data: state=%0d expected 2", dbg_state); errors++;
    end
    d0 = done_cnt;
    @(posedge clk); reset = 1'b0; #1;
    addrM = 4'd3; #1;
    checks++;
    if (dbg_state !== 3'd0 || load_busy !== 1'b0 || read_dataM !== 16'h0003 || load_count !== 5'd0) begin
      $display("FAIL midreset_state: state=%0d busy=%b mem3=%h count=%0d expected 0 0 0003 0",
               dbg_state, load_busy, read_dataM, load_count); errors++;
    end
    @(posedge clk); reset = 1'b1; #1;
    tick(); tick();
    checks++;
    if (done_cnt !== d0) begin
      $display("FAIL midreset_no_done: pulses=%0d expected 0", done_cnt - d0); errors++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [5];
    logic [7:0] crc;
    bytes = '{8'h02, 8'h34, 8'h12, 8'h78, 8'h56};
    crc = 8'h00;
    for (int i = 0; i < 5; i++) crc = ref_crc(crc, bytes[i]);
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(bytes[i]);
    send_byte(crc);
    checks++;
    if (load_done !== 1'b1 || load_err !== 1'b0 || load_count !== 5'd2) begin
      $display("FAIL two_word_done: done=%b err=%b count=%0d expected 1 0 2", load_done, load_err, load_count); errors++;
    end
    addrM = 4'd0; #1;
    checks++;
    if (read_dataM !== 16'h1234) begin
      $display("FAIL two_word_mem0: got %h expected 1234", read_dataM); errors++;
    end
    addrM = 4'd1; #1;
    checks++;
    if (read_dataM !== 16'h5678) begin
      $display("FAIL two_word_mem1: got %h expected 5678", read_dataM); errors++;
    end
    addrM = 4'd2; #1;
    checks++;
    if (read_dataM !== 16'h0002) begin
      $display("FAIL two_word_mem2: got %h expected 0002", read_dataM); errors++;
    end
  endtask

  initial begin
    errors = 0; checks = 0; done_cnt = 0;
    reset = 1'b0; write_en = 1'b0; addrM = '0; write_dataM = '0;
    load_start = 1'b0; rx_valid = 1'b0; rx_byte = '0;
    repeat (3) @(posedge clk);
    reset = 1'b1; #1;
    test_reset();
    test_good_frame();
    test_bad_crc();
    test_len_errors();
    test_stall();
    test_ignored_inputs();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_load_ram.md
# uart_load_ram

Parametrised CPU data RAM with a framed, CRC-checked UART bulk-load engine. The CPU side has one write port and one combinational read port. The load side takes a byte stream from the UART receiver, packs bytes into words, writes them from address 0 upward, and checks a trailing CRC-8. This block replaces the fixed 16x16 data memory in the 16-bit CPU datapath.

## Interface
Parameters:
- DATA_W, 16: word width; must be a multiple of 8. BYTES = DATA_W/8.
- DEPTH, 16: number of words; 2 ≤ DEPTH ≤ 255.
- ADDR_W, 4: address width; DEPTH ≤ 2^ADDR_W.

Ports:
- clk, input, 1: single clock. All state updates on the falling edge.
- reset, input, 1: asynchronous, active-low.
- write_en, input, 1: CPU write strobe.
- addrM, input, ADDR_W: CPU address, used for both read and write.
- write_dataM, input, DATA_W: CPU write data.
- read_dataM, output, DATA_W: combinational read of mem[addrM].
- load_start, input, 1: one-cycle pulse that starts a load frame.
- rx_valid, input, 1: one-cycle strobe; rx_byte is valid.
- rx_byte, input, 8: received byte.
- load_busy, output, 1: high in states LEN, DATA and CRC.
- cpu_stall, output, 1: equal to load_busy.
- load_done, output, 1: one-cycle pulse at the end of a frame, whether or not it failed.
- load_err, output, 1: sticky error flag; cleared by an accepted load_start.
- load_count, output, ADDR_W+1: number of words written in the current or last frame.

## Operation
- Reset:
  - mem[i] = i, zero-extended to DATA_W.
  - state = IDLE.
  - All outputs 0 except read_dataM, which shows the reset memory contents.
- Frame format: N (word count byte), then N×BYTES data bytes (low byte first within a word), then one CRC byte.
- CRC-8 definition:
  - Polynomial 0x07, init 0x00, MSB-first, no reflection, no final XOR.
  - Computed over N and all data bytes; the CRC byte itself is excluded.
- States and transitions:
  - IDLE, on load_start: clear crc, ptr, byte index, load_count and load_err; go to LEN.
  - LEN, on rx_valid:
    - If N == 0 or N > DEPTH: set load_err and go to DONE.
    - Otherwise latch N, fold N into crc, and go to DATA.
  - DATA, on each rx_valid:
    - Fold the byte into crc and place it in the assembly register at lane byte_idx.
    - On the last lane, write the word to mem[ptr], then increment ptr and load_count.
    - After word N is written, go to CRC.
  - CRC, on rx_valid:
    - If rx_byte != crc, set load_err.
    - Go to DONE.
  - DONE: assert load_done for one cycle, then return to IDLE.
- CPU write (mem[addrM] <= write_dataM) happens only when write_en = 1 and load_busy = 0. CPU writes while busy are dropped.
- Words written before a CRC error stay in memory; there is no rollback.
- Ignored inputs:
  - load_start while busy or in DONE.
  - rx_valid in IDLE or DONE.
- Arithmetic: ptr and load_count never wrap, because N ≤ DEPTH is enforced in LEN.

## Timing
- Byte acceptance: a byte is accepted on the falling edge where rx_valid = 1. At most one byte per cycle.
- Word write: occurs on the same falling edge as the last byte of the word. read_dataM reflects it combinationally after that edge.
- Busy flags: load_busy and cpu_stall rise on the edge that accepts load_start. They fall on the edge that accepts the CRC byte, or the rejected N byte.
- load_done is high for exactly the one cycle following the final byte.
- load_err:
  - Valid at load_done and held until the next accepted load_start.
  - An error from N appears on the N byte's edge.
  - A CRC error appears on the CRC byte's edge.
- load_start and rx_valid in the same cycle while in IDLE: the frame starts and the byte is ignored.
- Reset asserted mid-frame:
  - Immediate return to IDLE and reset memory contents.
  - Partial words are discarded.
  - No load_done pulse.

## Test plan
- Reset then read every address: read_dataM = addr for addr 0..15. Outputs busy = done = err = 0, load_count = 0.
- Good frame, defaults:
  - Stimulus: load_start, then bytes 0x01, 0x00, 0x00, 0x6B.
  - Response: mem[0] = 0x0000, load_count = 1, one load_done pulse, load_err = 0, mem[1] = 0x0001 unchanged.
- Bad CRC frame:
  - Stimulus: bytes 0x01, 0x00, 0x00, 0x6A.
  - Response: mem[0] = 0x0000 (kept), load_err = 1 at load_done and held, load_count = 1.
- Length errors:
  - N = 0x00 gives load_err = 1 and load_done on the next cycle, with no writes.
  - N = 0x11 (17 > DEPTH) behaves the same way.
- Stall:
  - Stimulus: write_en = 1 to addrM = 5 with data 0xBEEF while busy.
  - Response: mem[5] stays 5.
  - After done, the same write lands: read_dataM = 0xBEEF.
- Reset during DATA after 1 of 2 bytes: state returns to IDLE, mem is at reset values, and no load_done pulse occurs. A following full good frame succeeds.
